// File: rtl/midi_pkg.sv
// midi_pkg: shared types and helpers for the MIDI transmitter.
//   tx_state_t   : serializer frame state (IDLE, START, DATA, STOP)
//   midi_msg_len : number of bytes in a message, 0 for an invalid status byte
//   MIDI_BAUD, CLK_HZ_DEFAULT : default timing constants
package midi_pkg;

  localparam int MIDI_BAUD      = 31250;
  localparam int CLK_HZ_DEFAULT = 50_000_000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Message length from the status byte; 0 when bit 7 is clear (not a status).
  function automatic logic [1:0] midi_msg_len(input logic [7:0] status);
    logic [1:0] len;
    if (!status[7]) begin
      len = 2'd0;
    end else begin
      case (status[6:4])
        3'b100, 3'b101: len = 2'd2;          // Cx, Dx
        3'b111: begin                        // Fx system messages
          case (status[3:0])
            4'h2:       len = 2'd3;
            4'h1, 4'h3: len = 2'd2;
            default:    len = 2'd1;
          endcase
        end
        default: len = 2'd3;                 // 8x, 9x, Ax, Bx, Ex
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_tx_byte.sv
// midi_tx_byte: single-byte 8N1 serializer, LSB first, idle-high line.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load data and begin a frame (honoured in IDLE and in the
//                last cycle of STOP, so frames can run back to back)
//   data       : byte to send, sampled when start is accepted
//   serial     : registered line output
//   done       : high during the final cycle of the stop bit
module midi_tx_byte
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       serial,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t      state_r;
  logic [CW-1:0]  baud_r;
  logic [3:0]     bit_r;     // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]     shift_r;
  logic           serial_r;
  logic           bit_end_s;

  assign bit_end_s = (baud_r == BAUD_LAST);
  assign done      = (state_r == STOP) && bit_end_s;
  assign serial    = serial_r;

  // Frame FSM: baud counter, bit index, shift register and line driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      baud_r   <= '0;
      bit_r    <= 4'd0;
      shift_r  <= 8'h00;
      serial_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          baud_r <= '0;
          bit_r  <= 4'd0;
          if (start) begin
            shift_r  <= data;
            serial_r <= 1'b0;
            state_r  <= START;
          end
        end
        START: begin
          if (bit_end_s) begin
            baud_r   <= '0;
            bit_r    <= bit_r + 4'd1;
            serial_r <= shift_r[0];
            shift_r  <= {1'b0, shift_r[7:1]};
            state_r  <= DATA;
          end else begin
            baud_r <= baud_r + 1'b1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_r <= '0;
            bit_r  <= bit_r + 4'd1;
            if (bit_r == 4'd8) begin
              serial_r <= 1'b1;
              state_r  <= STOP;
            end else begin
              serial_r <= shift_r[0];
              shift_r  <= {1'b0, shift_r[7:1]};
            end
          end else begin
            baud_r <= baud_r + 1'b1;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            baud_r <= '0;
            bit_r  <= 4'd0;
            // Chain straight into the next start bit with no idle gap.
            if (start) begin
              shift_r  <= data;
              serial_r <= 1'b0;
              state_r  <= START;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            baud_r <= baud_r + 1'b1;
          end
        end
        default: begin
          state_r  <= IDLE;
          serial_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/midi_tx.sv
// midi_tx: MIDI DIN transmitter. Accepts one message (status + up to two
// data bytes) per valid/ready handshake and sends its bytes as back-to-back
// 8N1 frames through midi_tx_byte.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   msg_bytes  : [23:16] status, [15:8] data1, [7:0] data2
//   msg_valid  : message present; accepted when msg_ready is also high
//   msg_ready  : high only while idle
//   serial     : MIDI TX line, registered, idles high
//   busy       : high from accept until the final stop bit completes
//   msg_err    : one-cycle pulse after accepting a message whose status[7]==0
// Optional feature: define MIDI_RUNNING_STATUS_EN to omit a channel status
// byte (80..EF) that repeats the last transmitted status.
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEFAULT,
  parameter int BAUD         = MIDI_BAUD,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] msg_bytes,
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic        serial,
  output logic        busy,
  output logic        msg_err
);

  logic        msg_ready_r, busy_r, msg_err_r;
  logic [15:0] rest_r;     // bytes still to send, next one in [15:8]
  logic [1:0]  rem_r;      // count of bytes in rest_r
  logic [7:0]  status_s, d1_s, d2_s;
  logic [1:0]  len_s;
  logic        accept_s, skip_s, tx_start_s, tx_done_s;
  logic [7:0]  tx_data_s;

  assign status_s = msg_bytes[23:16];
  assign d1_s     = {1'b0, msg_bytes[14:8]};
  assign d2_s     = {1'b0, msg_bytes[6:0]};
  assign len_s    = midi_msg_len(status_s);
  assign accept_s = msg_valid && msg_ready_r;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] rs_r;        // last transmitted channel status, 0 = none

  assign skip_s = status_s[7] && (status_s < 8'hF0) && (status_s == rs_r);

  // Running-status register: channel status stored, F0..F7 clears, F8..FF keeps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_r <= 8'h00;
    end else if (accept_s && status_s[7]) begin
      if (status_s < 8'hF0) begin
        rs_r <= status_s;
      end else if (status_s <= 8'hF7) begin
        rs_r <= 8'h00;
      end else begin
        rs_r <= rs_r;
      end
    end else begin
      rs_r <= rs_r;
    end
  end
`else
  assign skip_s = 1'b0;
`endif

  // Byte feed: first byte at accept, following bytes in the last stop cycle.
  always_comb begin
    tx_start_s = 1'b0;
    tx_data_s  = 8'h00;
    if (accept_s && status_s[7]) begin
      tx_start_s = 1'b1;
      tx_data_s  = skip_s ? d1_s : status_s;
    end else if (busy_r && tx_done_s && (rem_r != 2'd0)) begin
      tx_start_s = 1'b1;
      tx_data_s  = rest_r[15:8];
    end else begin
      tx_start_s = 1'b0;
      tx_data_s  = 8'h00;
    end
  end

  // Message sequencer: handshake, byte queue and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      msg_err_r   <= 1'b0;
      rest_r      <= 16'h0000;
      rem_r       <= 2'd0;
    end else begin
      msg_err_r <= 1'b0;
      if (accept_s) begin
        if (!status_s[7]) begin
          msg_err_r <= 1'b1;     // dropped: stays idle and ready
        end else begin
          busy_r      <= 1'b1;
          msg_ready_r <= 1'b0;
          rest_r      <= skip_s ? {d2_s, 8'h00} : {d1_s, d2_s};
          rem_r       <= skip_s ? (len_s - 2'd2) : (len_s - 2'd1);
        end
      end else if (busy_r && tx_done_s) begin
        if (rem_r != 2'd0) begin
          rest_r <= {rest_r[7:0], 8'h00};
          rem_r  <= rem_r - 2'd1;
        end else begin
          busy_r      <= 1'b0;
          msg_ready_r <= 1'b1;
        end
      end else begin
        rem_r <= rem_r;
      end
    end
  end

  midi_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tx_start_s),
    .data   (tx_data_s),
    .serial (serial),
    .done   (tx_done_s)
  );

  assign msg_ready = msg_ready_r;
  assign busy      = busy_r;
  assign msg_err   = msg_err_r;

endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: self-checking bench for midi_tx. A reference model turns each
// message into the expected line waveform (one sample per clock) from the
// MIDI byte/framing rules; the captured line is compared sample by sample.
module tb_midi_tx;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] msg_bytes = 24'h000000;
  logic        msg_valid = 1'b0;
  logic        msg_ready, serial, busy, msg_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit exp_q[$];
  bit cap_q[$];
  logic [7:0] model_bytes[$];
`ifdef MIDI_RUNNING_STATUS_EN
  int model_rs = -1;
`endif

  midi_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_bytes (msg_bytes),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .serial    (serial),
    .busy      (busy),
    .msg_err   (msg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: byte list from the message rules, then one line sample per clock.
  function automatic void model_msg(input logic [23:0] m);
    logic [7:0] st;
    int n;
    bit skip;
    model_bytes.delete();
    exp_q.delete();
    st = m[23:16];
    if (!st[7]) return;
    if (st >= 8'hF0) n = (st == 8'hF2) ? 3 : ((st == 8'hF1 || st == 8'hF3) ? 2 : 1);
    else if (st >= 8'hC0 && st < 8'hE0) n = 2;
    else n = 3;
    skip = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
    if (st < 8'hF0) begin
      skip = (model_rs == int'(st));
      model_rs = int'(st);
    end else if (st <= 8'hF7) begin
      model_rs = -1;
    end
`endif
    if (!skip) model_bytes.push_back(st);
    if (n >= 2) model_bytes.push_back(m[15:8] & 8'h7F);
    if (n == 3) model_bytes.push_back(m[7:0] & 8'h7F);
    foreach (model_bytes[k]) begin
      repeat (CPB) exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back(model_bytes[k][i]);
      repeat (CPB) exp_q.push_back(1'b1);
    end
  endfunction

  // Mid-bit decode of byte k of the captured waveform.
  function automatic logic [7:0] decode(input int k);
    logic [7:0] v;
    int idx;
    v = 8'h00;
    for (int b = 0; b < 8; b++) begin
      idx = k * 10 * CPB + (b + 1) * CPB + CPB / 2;
      v[b] = (idx < cap_q.size()) ? cap_q[idx] : 1'b0;
    end
    return v;
  endfunction

  // Wait (bounded) for msg_ready, then present a message; called at a negedge.
  task automatic start_msg(input logic [23:0] m, input string tag);
    int n;
    n = 0;
    while (msg_ready !== 1'b1 && n < 50 * CPB) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_wait"}, {31'd0, msg_ready}, 32'd1);
    msg_bytes = m;
    msg_valid = 1'b1;
  endtask

  // Accept the presented message m and capture the line until busy drops.
  task automatic run_frame(input logic [23:0] m, input logic hold, input logic [23:0] nxt,
                           input string tag);
    int n, ready_hi, mism;
    model_msg(m);
    cap_q.delete();
    ready_hi = 0;
    n = 0;
    @(negedge clk);
    if (hold) msg_bytes = nxt;
    else begin
      msg_valid = 1'b0;
      msg_bytes = $urandom;
    end
    check({tag, "_err"}, {31'd0, msg_err}, {31'd0, ~m[23]});
    while (busy === 1'b1 && n < 40 * CPB) begin
      cap_q.push_back(serial);
      if (msg_ready !== 1'b0) ready_hi++;
      @(negedge clk);
      n++;
    end
    mism = 0;
    foreach (exp_q[i]) if (i >= cap_q.size() || cap_q[i] !== exp_q[i]) mism++;
    check({tag, "_busy_len"}, cap_q.size(), exp_q.size());
    check({tag, "_wave_mism"}, mism, 0);
    check({tag, "_ready_in_busy"}, ready_hi, 0);
    check({tag, "_idle_serial"}, {31'd0, serial}, 32'd1);
    check({tag, "_idle_ready"}, {31'd0, msg_ready}, 32'd1);
  endtask

  task automatic send(input logic [23:0] m, input string tag);
    start_msg(m, tag);
    run_frame(m, 1'b0, 24'h000000, tag);
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [23:0] m;
    int bad;
    pool[0] = 8'h90; pool[1] = 8'h90; pool[2] = 8'hC3; pool[3] = 8'hF8;
    pool[4] = 8'hF0; pool[5] = 8'hF2; pool[6] = 8'hF1; pool[7] = 8'h35;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_serial", {31'd0, serial}, 32'd1);
    check("rst_ready", {31'd0, msg_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, msg_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full note-on, 30 bits, exact bytes
    send(24'h90047F, "t1");
    check("t1_len", cap_q.size(), 30 * CPB);
    check("t1_b0", {24'd0, decode(0)}, 32'h90);
    check("t1_b1", {24'd0, decode(1)}, 32'h04);
    check("t1_b2", {24'd0, decode(2)}, 32'h7F);

    // 2: program change, 20 bits
    send(24'h C510AA, "t2");
    check("t2_len", cap_q.size(), 20 * CPB);

    // 3: realtime single byte; data bit7 masking
    send(24'hF81234, "t3a");
    check("t3a_len", cap_q.size(), 10 * CPB);
    send(24'h9084FF, "t3b");
    check("t3b_len", cap_q.size(), 30 * CPB);
    check("t3b_b1", {24'd0, decode(1)}, 32'h04);
    check("t3b_b2", {24'd0, decode(2)}, 32'h7F);

    // 4: second message held on the inputs during the first frame
    start_msg(24'hB00710, "t4a");
    run_frame(24'hB00710, 1'b1, 24'hE01234, "t4a");
    run_frame(24'hE01234, 1'b0, 24'h000000, "t4b");

    // 5: reset in the middle of a data bit
    start_msg(24'h90047F, "t5");
    @(negedge clk);
    msg_valid = 1'b0;
    repeat (3 * CPB + CPB / 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_serial", {31'd0, serial}, 32'd1);
    check("t5_rst_ready", {31'd0, msg_ready}, 32'd1);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
`ifdef MIDI_RUNNING_STATUS_EN
    model_rs = -1;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40 * CPB) begin
      @(negedge clk);
      if (serial !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t5_residual", bad, 0);
    send(24'h401122, "t5err");
    @(negedge clk);
    check("t5_err_pulse_end", {31'd0, msg_err}, 32'd0);
    check("t5_err_serial", {31'd0, serial}, 32'd1);

`ifdef MIDI_RUNNING_STATUS_EN
    // 6: running status
    send(24'hF00000, "t6clr");
    send(24'h903C40, "t6a");
    check("t6a_len", cap_q.size(), 30 * CPB);
    send(24'h903E40, "t6b");
    check("t6b_len", cap_q.size(), 20 * CPB);
    send(24'hF80000, "t6c");
    send(24'h904040, "t6d");
    check("t6d_len", cap_q.size(), 20 * CPB);
`endif

    // Randomized messages against the model
    for (int r = 0; r < 30; r++) begin
      m = $urandom;
      m[23:16] = pool[$urandom_range(0, 7)];
      send(m, "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
